dfd_tnif_rx: RTL and testbench
==============================

// Module: dfd_tnif_rx
// PURPOSE
//  Receive end of the trace network source interface. Accepts arbitrated beats
//  (tr_valid/tr_src/tr_data) and steers them into per-source FIFOs (DST, NTR).
//  Presents each FIFO to the downstream trace sink with valid/ready.
//  Generates the grant, per-source backpressure and flush signals seen by the
//  source-side interface.
// PARAMETERS
//  DATA_WIDTH_IN_BYTES  TNIF_DATA_OUT_WIDTH_IN_BYTES  beat width in bytes
//  FIFO_DEPTH           8   entries per source FIFO; power of 2, >=4
//  BP_MARGIN            2   free entries held back when bp asserts; >=2
//  DROP_CNT_WIDTH       16  drop counter width (DFD_TNIF_RX_DROP_CNT_EN only)
// PORTS
//  clock               in   1     clock
//  reset               in   1     synchronous reset, active-high
//  tr_valid_in         in   1     beat valid from trace network
//  tr_src_in           in   1     0=DST, 1=NTR
//  tr_data_in          in   W*8   beat data (W=DATA_WIDTH_IN_BYTES)
//  tr_gnt_out          out  1     grant to source side
//  dst_bp_out/ntr_bp_out          out 1   per-source backpressure
//  dst_flush_out/ntr_flush_out    out 1   per-source flush, overrides source bp
//  dst_flush_req_in/ntr_flush_req_in in 1 flush request from sink control (level)
//  dst_flush_done_out/ntr_flush_done_out out 1  one-cycle pulse at flush end
//  dst_valid_out/ntr_valid_out    out 1   FIFO head valid to sink
//  dst_data_out/ntr_data_out      out W*8 FIFO head data
//  dst_ready_in/ntr_ready_in      in  1   sink accepts head
//  dst_overflow_out/ntr_overflow_out out 1 sticky: beat arrived while FIFO full
//  dst_drop_cnt_out/ntr_drop_cnt_out out DROP_CNT_WIDTH  (macro only)
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs empty, flush FSMs in RUN. tr_gnt_out is
//   registered and rises the first cycle after reset deasserts. Reset mid-traffic
//   discards all stored beats.
//  Steering: tr_valid_in & ~tr_src_in pushes DST; tr_valid_in & tr_src_in pushes NTR.
//  Latency: a pushed beat appears at *_valid_out the next cycle; no bypass path.
//  Pop: *_valid_out & *_ready_in. Data is held stable while valid & ~ready.
//  Push + pop in one cycle: both happen, including when full (occupancy unchanged,
//   no overflow) and when empty (valid stays on).
//  Push while full without pop: beat dropped, *_overflow_out set (cleared only by
//   reset), drop counter +1.
//  Backpressure: *_bp_out is registered.
//   next = (next-cycle occupancy >= FIFO_DEPTH-BP_MARGIN).
//   BP_MARGIN covers the registered-bp latency, so a compliant source never
//   overflows.
//  Pointers: log2(FIFO_DEPTH) bits plus one wrap bit.
//   full  = MSB differs and low bits are equal.
//   empty = pointers are equal.
//  Flush FSM (per source, tnifRxFlushState_e):
//   RUN  -> FLUSH  on *_flush_req_in.
//   FLUSH -> DONE  when *_flush_req_in drops.
//   DONE -> RUN    unconditionally.
//   On entry to FLUSH: FIFO cleared the same cycle.
//   In FLUSH: *_flush_out=1, *_valid_out=0, bp=0, and incoming beats for that
//   source are discarded without setting overflow or counting drops.
//   *_flush_done_out=1 in DONE only.
//   The other source is unaffected. Both sources may flush concurrently.
// CONFIGURATION
//  DFD_TNIF_RX_DROP_CNT_EN defined:
//   per-source saturating DROP_CNT_WIDTH drop counters exist, with output ports;
//   counters clear on reset only.
//  Not defined: counters and drop_cnt ports are absent; overflow flags remain.
// STRUCTURE
//  dfd_tn_pkg: add tnifRxFlushState_e {RUN, FLUSH, DONE} and
//   TNIF_RX_SRC_DST=1'b0 / TNIF_RX_SRC_NTR=1'b1. These reuse the src encoding of
//   the tx side.
//  Sub-module dfd_tnif_rx_fifo (push, pop, clear, data, occupancy, full, empty),
//   instantiated twice. Flush FSM, bp and counters stay in the top module.
//  Assertion: never pop when empty; bp never asserted with occupancy < threshold.
// TESTING (FIFO_DEPTH=8, BP_MARGIN=2)
//  1 Reset:
//    release reset -> all outputs 0 cycle 0, tr_gnt_out=1 from cycle 1.
//  2 Steering:
//    beats 0xA0(src0), 0xB0(src1), 0xA1(src0), ready=1 -> dst sees A0,A1 and
//    ntr sees B0, each one cycle after push, in order.
//  3 Backpressure:
//    dst_ready=0, 6 DST pushes -> dst_bp_out=1 the cycle after the 6th push;
//    ntr_bp_out stays 0; one pop with no push -> bp falls the next cycle.
//  4 Overflow:
//    dst_ready=0, 10 DST pushes ignoring bp -> 8 stored, dst_overflow_out=1,
//    drop_cnt=2 (macro on); pops return the first 8 beats in order.
//  5 Flush:
//    3 DST beats stored, dst_flush_req_in high 4 cycles with 2 DST beats
//    arriving -> next cycle dst_valid_out=0 and dst_flush_out=1; done pulses
//    1 cycle after req drops; FIFO empty; overflow and drop_cnt unchanged;
//    NTR traffic continues.
//  6 Boundaries:
//    full DST FIFO with simultaneous push+pop -> accepted, no overflow;
//    assert reset mid-stream -> FIFOs empty, overflow 0, FSM RUN next cycle.

Source files
------------

// File: rtl/dfd_tn_pkg.sv
// dfd_tn_pkg: shared trace-network types and constants.
// Holds the flush-state encoding of the receive interface and the source
// encoding that the tx side also uses on tr_src.
// Ports: none (package).
package dfd_tn_pkg;

  localparam int TNIF_DATA_OUT_WIDTH_IN_BYTES = 4;

  localparam logic TNIF_RX_SRC_DST = 1'b0;
  localparam logic TNIF_RX_SRC_NTR = 1'b1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } tnifRxFlushState_e;

endpackage

// File: rtl/dfd_tnif_rx_if.sv
// dfd_tnif_rx_if: bundle of trace-network beat input, source-side control
// (grant, backpressure, flush) and per-source sink handshakes.
// Modports: master = trace network / sink side (drives *_in),
//           slave  = dfd_tnif_rx (drives *_out).
// Drop-counter signals exist only with DFD_TNIF_RX_DROP_CNT_EN defined.
interface dfd_tnif_rx_if
  import dfd_tn_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = TNIF_DATA_OUT_WIDTH_IN_BYTES,
  parameter int DROP_CNT_WIDTH      = 16
);
  localparam int DW = DATA_WIDTH_IN_BYTES * 8;

  logic          tr_valid_in;
  logic          tr_src_in;
  logic [DW-1:0] tr_data_in;
  logic          tr_gnt_out;
  logic          dst_bp_out,         ntr_bp_out;
  logic          dst_flush_out,      ntr_flush_out;
  logic          dst_flush_req_in,   ntr_flush_req_in;
  logic          dst_flush_done_out, ntr_flush_done_out;
  logic          dst_valid_out,      ntr_valid_out;
  logic [DW-1:0] dst_data_out,       ntr_data_out;
  logic          dst_ready_in,       ntr_ready_in;
  logic          dst_overflow_out,   ntr_overflow_out;
`ifdef DFD_TNIF_RX_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] dst_drop_cnt_out, ntr_drop_cnt_out;
`endif

  modport master (
    output tr_valid_in, tr_src_in, tr_data_in,
    output dst_flush_req_in, ntr_flush_req_in, dst_ready_in, ntr_ready_in,
    input  tr_gnt_out, dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out,
    input  dst_flush_done_out, ntr_flush_done_out,
    input  dst_valid_out, ntr_valid_out, dst_data_out, ntr_data_out,
`ifdef DFD_TNIF_RX_DROP_CNT_EN
    input  dst_drop_cnt_out, ntr_drop_cnt_out,
`endif
    input  dst_overflow_out, ntr_overflow_out
  );

  modport slave (
    input  tr_valid_in, tr_src_in, tr_data_in,
    input  dst_flush_req_in, ntr_flush_req_in, dst_ready_in, ntr_ready_in,
    output tr_gnt_out, dst_bp_out, ntr_bp_out, dst_flush_out, ntr_flush_out,
    output dst_flush_done_out, ntr_flush_done_out,
    output dst_valid_out, ntr_valid_out, dst_data_out, ntr_data_out,
`ifdef DFD_TNIF_RX_DROP_CNT_EN
    output dst_drop_cnt_out, ntr_drop_cnt_out,
`endif
    output dst_overflow_out, ntr_overflow_out
  );

endinterface

// File: rtl/dfd_tnif_rx_chk.sv
// dfd_tnif_rx_chk: property checker bound per source inside dfd_tnif_rx.
// Ports: clock/reset, pop/empty of the FIFO, registered bp and occupancy.
// Also checks the parameter legality (depth power of 2 >= 4, margin >= 2).
module dfd_tnif_rx_chk #(
  parameter int FIFO_DEPTH     = 8,
  parameter int BP_MARGIN      = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input logic                        clock,
  input logic                        reset,
  input logic                        pop,
  input logic                        empty,
  input logic                        bp,
  input logic [$clog2(FIFO_DEPTH):0] occupancy
);
  localparam int THR = FIFO_DEPTH - BP_MARGIN;

  a_cfg: assert property (@(posedge clock)
    (FIFO_DEPTH >= 4) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
    (BP_MARGIN >= 2) && (DROP_CNT_WIDTH >= 1));

  a_no_pop_empty: assert property (@(posedge clock) disable iff (reset)
    !(pop && empty));

  a_bp_thr: assert property (@(posedge clock) disable iff (reset)
    bp |-> (int'(occupancy) >= THR));

endmodule

// File: rtl/dfd_tnif_rx_fifo.sv
// dfd_tnif_rx_fifo: per-source receive FIFO with wrap-bit pointers.
// Ports: clock/reset; push/pop/clear strobes (caller guarantees push only
// when not full or popping, pop only when not empty); din/dout head data;
// occupancy, full, empty status. clear empties the FIFO in one cycle.
module dfd_tnif_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;

  // Pointer update; clear and reset both return to empty.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr_r <= {OW{1'b0}};
      rd_ptr_r <= {OW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + OW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + OW'(1);
      end
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  assign dout      = mem_r[rd_ptr_r[AW-1:0]];
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign occupancy = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/dfd_tnif_rx.sv
// dfd_tnif_rx: receive end of the trace network source interface.
// Steers arbitrated beats into DST/NTR FIFOs, presents each to the sink with
// valid/ready, and generates grant, per-source backpressure and flush.
// Ports: clock, reset (sync, active-high), tn (dfd_tnif_rx_if.slave).
// Optional: DFD_TNIF_RX_DROP_CNT_EN adds saturating per-source drop counters.
module dfd_tnif_rx
  import dfd_tn_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = TNIF_DATA_OUT_WIDTH_IN_BYTES,
  parameter int FIFO_DEPTH          = 8,
  parameter int BP_MARGIN           = 2,
  parameter int DROP_CNT_WIDTH      = 16
) (
  input logic          clock,
  input logic          reset,
  dfd_tnif_rx_if.slave tn
);
  localparam int DW = DATA_WIDTH_IN_BYTES * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [AW:0] BP_THR = OW'(FIFO_DEPTH - BP_MARGIN);

  logic          gnt_r;
  logic [1:0]    flush_req_a, ready_a, valid_a, bp_a, flush_a, done_a, ovf_a;
  logic [DW-1:0] data_a [2];
`ifdef DFD_TNIF_RX_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] cnt_a [2];
`endif

  assign flush_req_a = {tn.ntr_flush_req_in, tn.dst_flush_req_in};
  assign ready_a     = {tn.ntr_ready_in, tn.dst_ready_in};

  // Grant comes up the first cycle after reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_r <= 1'b0;
    end else begin
      gnt_r <= 1'b1;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_src
    localparam logic SRC_ID = (s == 0) ? TNIF_RX_SRC_DST : TNIF_RX_SRC_NTR;

    tnifRxFlushState_e state_r, state_nxt_s;
    logic          clear_s, discard_s, push_s, pop_s, drop_s, wr_s;
    logic          full_s, empty_s, valid_s, bp_r, ovf_r;
    logic [AW:0]   occ_s, occ_nxt_s;
    logic [DW-1:0] head_s;

    // Flush state register.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_r <= RUN;
      end else begin
        state_r <= state_nxt_s;
      end
    end

    // Flush next state; the FIFO is cleared on the cycle FLUSH is entered.
    always_comb begin
      state_nxt_s = state_r;
      clear_s     = 1'b0;
      case (state_r)
        RUN: begin
          if (flush_req_a[s]) begin
            state_nxt_s = FLUSH;
            clear_s     = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        FLUSH: begin
          if (!flush_req_a[s]) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = FLUSH;
          end
        end
        DONE:    state_nxt_s = RUN;
        default: state_nxt_s = RUN;
      endcase
    end

    // Beats for a flushing source vanish silently (no overflow, no drop count).
    assign discard_s = clear_s || (state_r == FLUSH);
    assign push_s    = tn.tr_valid_in && (tn.tr_src_in == SRC_ID) && !discard_s;
    assign valid_s   = !empty_s && (state_r != FLUSH);
    assign pop_s     = valid_s && ready_a[s] && !clear_s;
    assign drop_s    = push_s && full_s && !pop_s;
    assign wr_s      = push_s && !drop_s;

    dfd_tnif_rx_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (wr_s),
      .pop       (pop_s),
      .clear     (clear_s),
      .din       (tn.tr_data_in),
      .dout      (head_s),
      .occupancy (occ_s),
      .full      (full_s),
      .empty     (empty_s)
    );

    // Occupancy the FIFO will hold after this edge, used for registered bp.
    always_comb begin
      occ_nxt_s = occ_s;
      if (clear_s) begin
        occ_nxt_s = {OW{1'b0}};
      end else begin
        occ_nxt_s = occ_s + OW'(wr_s) - OW'(pop_s);
      end
    end

    // Backpressure and sticky overflow.
    always_ff @(posedge clock) begin
      if (reset) begin
        bp_r  <= 1'b0;
        ovf_r <= 1'b0;
      end else begin
        bp_r  <= (occ_nxt_s >= BP_THR);
        ovf_r <= ovf_r || drop_s;
      end
    end

`ifdef DFD_TNIF_RX_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] cnt_r;

    // Saturating drop counter.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_r <= {DROP_CNT_WIDTH{1'b0}};
      end else if (drop_s && (cnt_r != {DROP_CNT_WIDTH{1'b1}})) begin
        cnt_r <= cnt_r + DROP_CNT_WIDTH'(1);
      end
    end
    assign cnt_a[s] = cnt_r;
`endif

    assign valid_a[s] = valid_s;
    assign data_a[s]  = valid_s ? head_s : {DW{1'b0}};
    assign bp_a[s]    = bp_r;
    assign flush_a[s] = (state_r == FLUSH);
    assign done_a[s]  = (state_r == DONE);
    assign ovf_a[s]   = ovf_r;

    dfd_tnif_rx_chk #(
      .FIFO_DEPTH(FIFO_DEPTH), .BP_MARGIN(BP_MARGIN), .DROP_CNT_WIDTH(DROP_CNT_WIDTH)
    ) u_chk (
      .clock(clock), .reset(reset), .pop(pop_s), .empty(empty_s),
      .bp(bp_r), .occupancy(occ_s)
    );
  end

  assign tn.tr_gnt_out         = gnt_r;
  assign tn.dst_valid_out      = valid_a[0];
  assign tn.ntr_valid_out      = valid_a[1];
  assign tn.dst_data_out       = data_a[0];
  assign tn.ntr_data_out       = data_a[1];
  assign tn.dst_bp_out         = bp_a[0];
  assign tn.ntr_bp_out         = bp_a[1];
  assign tn.dst_flush_out      = flush_a[0];
  assign tn.ntr_flush_out      = flush_a[1];
  assign tn.dst_flush_done_out = done_a[0];
  assign tn.ntr_flush_done_out = done_a[1];
  assign tn.dst_overflow_out   = ovf_a[0];
  assign tn.ntr_overflow_out   = ovf_a[1];
`ifdef DFD_TNIF_RX_DROP_CNT_EN
  assign tn.dst_drop_cnt_out   = cnt_a[0];
  assign tn.ntr_drop_cnt_out   = cnt_a[1];
`endif

endmodule

// File: tb/tb_dfd_tnif_rx.sv
// tb_dfd_tnif_rx: directed + randomized bench for dfd_tnif_rx against a
// queue-based reference model (FIFO_DEPTH=8, BP_MARGIN=2, 4-byte beats).
`timescale 1ns/1ps
module tb_dfd_tnif_rx;
  import dfd_tn_pkg::*;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int M  = 2;
  localparam int CW = 16;

  typedef logic [31:0] word_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dfd_tnif_rx_if #(.DATA_WIDTH_IN_BYTES(W), .DROP_CNT_WIDTH(CW)) tn ();

  dfd_tnif_rx #(
    .DATA_WIDTH_IN_BYTES(W), .FIFO_DEPTH(D), .BP_MARGIN(M), .DROP_CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .tn(tn.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // stimulus registers
  bit    i_rst, i_v, i_src;
  word_t i_d;
  bit    i_req [2];
  bit    i_rdy [2];

  // reference model: mode 0 running, 1 flushing, 2 flush just finished
  word_t mq [2][$];
  int    mode [2];
  bit    m_ovf [2];
  int    m_cnt [2];
  bit    m_bp [2];
  bit    m_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (i_rst) begin
      m_gnt = 1'b0;
      for (int s = 0; s < 2; s++) begin
        mq[s].delete();
        mode[s] = 0; m_ovf[s] = 1'b0; m_cnt[s] = 0; m_bp[s] = 1'b0;
      end
    end else begin
      m_gnt = 1'b1;
      for (int s = 0; s < 2; s++) begin
        bit pop;
        bit hit;
        pop = (mq[s].size() > 0) && (mode[s] != 1) && i_rdy[s];
        hit = i_v && (int'(i_src) == s);
        if (mode[s] == 0 && i_req[s]) begin
          mq[s].delete();
          mode[s] = 1;
        end else if (mode[s] == 1) begin
          mode[s] = i_req[s] ? 1 : 2;
        end else begin
          mode[s] = 0;
          if (pop) void'(mq[s].pop_front());
          if (hit) begin
            if (mq[s].size() < D) mq[s].push_back(i_d);
            else begin
              m_ovf[s] = 1'b1;
              if (m_cnt[s] < (1 << CW) - 1) m_cnt[s]++;
            end
          end
        end
        m_bp[s] = (mq[s].size() >= D - M);
      end
    end
  endtask

  task automatic check_all();
    logic        o_valid [2], o_bp [2], o_fl [2], o_done [2], o_ovf [2];
    word_t       o_data [2];
    string       nm [2];
    nm[0] = "dst"; nm[1] = "ntr";
    o_valid[0] = tn.dst_valid_out;      o_valid[1] = tn.ntr_valid_out;
    o_data[0]  = tn.dst_data_out;       o_data[1]  = tn.ntr_data_out;
    o_bp[0]    = tn.dst_bp_out;         o_bp[1]    = tn.ntr_bp_out;
    o_fl[0]    = tn.dst_flush_out;      o_fl[1]    = tn.ntr_flush_out;
    o_done[0]  = tn.dst_flush_done_out; o_done[1]  = tn.ntr_flush_done_out;
    o_ovf[0]   = tn.dst_overflow_out;   o_ovf[1]   = tn.ntr_overflow_out;
    chk("gnt", 64'(tn.tr_gnt_out), 64'(m_gnt));
    for (int s = 0; s < 2; s++) begin
      bit    ev;
      word_t ed;
      ev = (mq[s].size() > 0) && (mode[s] != 1);
      ed = ev ? mq[s][0] : 32'h0;
      chk({nm[s], "_valid"}, 64'(o_valid[s]), 64'(ev));
      chk({nm[s], "_data"},  64'(o_data[s]),  64'(ed));
      chk({nm[s], "_bp"},    64'(o_bp[s]),    64'(m_bp[s]));
      chk({nm[s], "_flush"}, 64'(o_fl[s]),    64'(mode[s] == 1));
      chk({nm[s], "_done"},  64'(o_done[s]),  64'(mode[s] == 2));
      chk({nm[s], "_ovf"},   64'(o_ovf[s]),   64'(m_ovf[s]));
    end
`ifdef DFD_TNIF_RX_DROP_CNT_EN
    chk("dst_drop_cnt", 64'(tn.dst_drop_cnt_out), 64'(m_cnt[0]));
    chk("ntr_drop_cnt", 64'(tn.ntr_drop_cnt_out), 64'(m_cnt[1]));
`endif
  endtask

  // drive inputs (away from the edge), clock once, update model, compare
  task automatic step();
    reset               = i_rst;
    tn.tr_valid_in      = i_v;
    tn.tr_src_in        = i_src;
    tn.tr_data_in       = i_d;
    tn.dst_flush_req_in = i_req[0];
    tn.ntr_flush_req_in = i_req[1];
    tn.dst_ready_in     = i_rdy[0];
    tn.ntr_ready_in     = i_rdy[1];
    @(posedge clock);
    model_update();
    #1;
    check_all();
  endtask

  task automatic beat(input bit src, input word_t d);
    i_v = 1'b1; i_src = src; i_d = d;
    step();
    i_v = 1'b0;
  endtask

  task automatic idle(input int n);
    i_v = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_v = 1'b0; i_req[0] = 1'b0; i_req[1] = 1'b0;
    step(); step();
    i_rst = 1'b0;
  endtask

  initial begin
    int hold [2];
    i_rst = 1'b1; i_v = 1'b0; i_src = 1'b0; i_d = 32'h0;
    i_req[0] = 1'b0; i_req[1] = 1'b0; i_rdy[0] = 1'b0; i_rdy[1] = 1'b0;

    // 1 reset: cycle 0 all zero, grant from cycle 1
    do_reset();
    chk("t1_gnt_c0", 64'(tn.tr_gnt_out), 64'd0);
    idle(1);
    chk("t1_gnt_c1", 64'(tn.tr_gnt_out), 64'd1);

    // 2 steering
    i_rdy[0] = 1'b1; i_rdy[1] = 1'b1;
    beat(1'b0, 32'hA0);
    chk("t2_dst_a0", 64'(tn.dst_data_out), 64'h0A0);
    beat(1'b1, 32'hB0);
    chk("t2_ntr_b0", 64'(tn.ntr_data_out), 64'h0B0);
    beat(1'b0, 32'hA1);
    chk("t2_dst_a1", 64'(tn.dst_data_out), 64'h0A1);
    idle(2);

    // 3 backpressure
    i_rdy[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) chk("t3_bp_before6", 64'(tn.dst_bp_out), 64'd0);
      beat(1'b0, 32'h300 + 32'(k));
    end
    chk("t3_bp_after6", 64'(tn.dst_bp_out), 64'd1);
    chk("t3_ntr_bp", 64'(tn.ntr_bp_out), 64'd0);
    i_rdy[0] = 1'b1;
    idle(1);
    chk("t3_bp_fall", 64'(tn.dst_bp_out), 64'd0);
    idle(6);

    // 4 overflow
    i_rdy[0] = 1'b0;
    for (int k = 0; k < 10; k++) beat(1'b0, 32'h400 + 32'(k));
    chk("t4_ovf", 64'(tn.dst_overflow_out), 64'd1);
    chk("t4_head", 64'(tn.dst_data_out), 64'h400);
    i_rdy[0] = 1'b1;
    idle(9);
    chk("t4_drained", 64'(tn.dst_valid_out), 64'd0);

    // 5 flush with NTR traffic alongside
    i_rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) beat(1'b0, 32'h500 + 32'(k));
    i_req[0] = 1'b1;
    beat(1'b1, 32'h5B0);
    chk("t5_valid_off", 64'(tn.dst_valid_out), 64'd0);
    chk("t5_flush_on", 64'(tn.dst_flush_out), 64'd1);
    beat(1'b0, 32'h5A0);
    beat(1'b1, 32'h5B1);
    beat(1'b0, 32'h5A1);
    i_req[0] = 1'b0;
    idle(1);
    chk("t5_done", 64'(tn.dst_flush_done_out), 64'd1);
    idle(1);
    chk("t5_done_clr", 64'(tn.dst_flush_done_out), 64'd0);
    chk("t5_empty", 64'(tn.dst_valid_out), 64'd0);
    chk("t5_ovf_kept", 64'(tn.dst_overflow_out), 64'd1);

    // 6 boundaries: full push+pop, then reset mid-stream
    do_reset();
    i_rdy[0] = 1'b0;
    for (int k = 0; k < 8; k++) beat(1'b0, 32'h600 + 32'(k));
    i_rdy[0] = 1'b1;
    beat(1'b0, 32'h6FF);
    chk("t6_full_pp_ovf", 64'(tn.dst_overflow_out), 64'd0);
    chk("t6_full_pp_head", 64'(tn.dst_data_out), 64'h601);
    i_rdy[0] = 1'b0;
    beat(1'b1, 32'h6B0);
    do_reset();
    chk("t6_rst_valid", 64'(tn.dst_valid_out), 64'd0);
    chk("t6_rst_flush", 64'(tn.dst_flush_out), 64'd0);

    // randomized traffic
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      i_rst = ($urandom_range(0, 799) == 0);
      i_v   = ($urandom_range(0, 3) != 0);
      i_src = 1'($urandom_range(0, 1));
      i_d   = $urandom;
      for (int s = 0; s < 2; s++) begin
        i_rdy[s] = ($urandom_range(0, 2) != 0);
        if (hold[s] > 0) hold[s]--;
        else if ($urandom_range(0, 59) == 0) hold[s] = $urandom_range(1, 5);
        i_req[s] = (hold[s] > 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
